// File: rtl/midi_parser_pkg.sv
// Types and helpers for the MIDI byte-stream parser.
//   state_t      : parser state machine encoding
//   entry_state  : state entered after a channel status byte is latched
`include "midi_defs.vh"

package midi_parser_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DATA1 = 3'd1,
    DATA2 = 3'd2,
    SKIP1 = 3'd3,
    SKIP2 = 3'd4,
    SYSEX = 3'd5
  } state_t;

  // Note-off/on go to the note parser. Program change (0xCn) and channel
  // pressure (0xDn) carry one data byte. All others carry two.
  function automatic state_t entry_state(input logic [7:0] status);
    if (status[7:4] == `NOTE_OFF >> 4 || status[7:4] == `NOTE_ON >> 4)
      return DATA1;
    else if (status[7:4] == 4'hC || status[7:4] == 4'hD)
      return SKIP1;
    else
      return SKIP2;
  endfunction

endpackage

// File: rtl/midi_defs.vh
// MIDI status byte constants shared by the MIDI parser and the synth voice
// allocator that consumes its events. These are macros, so every module in
// the compilation unit can use them. The include guard keeps repeated
// inclusion harmless.
`ifndef MIDI_DEFS_VH
`define MIDI_DEFS_VH

`define NOTE_OFF     8'h80
`define NOTE_ON      8'h90
`define SYSEX_START  8'hF0
`define SYSEX_END    8'hF7
`define REALTIME_MIN 8'hF8

`endif

// File: rtl/midi_parser.sv
// MIDI byte-stream parser.
// Decodes note-on and note-off channel messages, including running status.
// Realtime bytes are transparent. SysEx and all other messages are skipped.
// Ports:
//   clk       : system clock
//   reset     : synchronous, active-high
//   in_data   : received byte
//   in_valid  : one-cycle strobe qualifying in_data
//   note_on   : one-cycle event strobe
//   note_off  : one-cycle event strobe
//   channel   : event field, held until the next event
//   note      : event field, held until the next event
//   velocity  : event field, held until the next event
// Parameters:
//   OMNI      : 1 accepts all channels; 0 accepts only CHANNEL
//   CHANNEL   : channel accepted when OMNI is 0
`include "midi_defs.vh"

module midi_parser
  import midi_parser_pkg::*;
#(
  parameter bit         OMNI    = 1'b1,
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       note_on,
  output logic       note_off,
  output logic [3:0] channel,
  output logic [6:0] note,
  output logic [6:0] velocity
);

  state_t     state, state_next;
  logic [7:0] run_status, run_status_next;
  logic [6:0] note_lat, note_lat_next;
  logic       emit_on, emit_off;
  logic       accept;

  assign accept = OMNI || (run_status[3:0] == CHANNEL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      run_status <= 8'h00;
      note_lat   <= 7'h00;
      note_on    <= 1'b0;
      note_off   <= 1'b0;
      channel    <= 4'h0;
      note       <= 7'h00;
      velocity   <= 7'h00;
    end else begin
      state      <= state_next;
      run_status <= run_status_next;
      note_lat   <= note_lat_next;
      note_on    <= emit_on;
      note_off   <= emit_off;
      if (emit_on || emit_off) begin
        channel  <= run_status[3:0];
        note     <= note_lat;
        velocity <= in_data[6:0];
      end
    end
  end

  always_comb begin
    state_next      = state;
    run_status_next = run_status;
    note_lat_next   = note_lat;
    emit_on         = 1'b0;
    emit_off        = 1'b0;
    // Realtime bytes fall through untouched.
    if (in_valid && in_data < `REALTIME_MIN) begin
      if (in_data == `SYSEX_START) begin
        run_status_next = 8'h00;
        state_next      = SYSEX;
      end else if (in_data[7:4] == 4'hF) begin
        // System common, including SYSEX_END: drop running status.
        run_status_next = 8'h00;
        state_next      = IDLE;
      end else if (in_data[7]) begin
        // A new status byte aborts any partial message.
        run_status_next = in_data;
        state_next      = entry_state(in_data);
      end else begin
        case (state)
          DATA1: begin
            note_lat_next = in_data[6:0];
            state_next    = DATA2;
          end
          DATA2: begin
            state_next = DATA1;
            if (accept) begin
              // Note-on with zero velocity is treated as note-off.
              if (run_status[7:4] == (`NOTE_ON >> 4) && in_data[6:0] != 7'h00)
                emit_on = 1'b1;
              else
                emit_off = 1'b1;
            end
          end
          SKIP2: state_next = SKIP1;
          // Return to the message's first skip state.
          SKIP1: state_next = entry_state(run_status);
          default: state_next = state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_midi_parser.sv
// Directed testbench for midi_parser.
// An OMNI instance and a CHANNEL=2 instance share the same input byte stream.
module tb_midi_parser;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       on1, off1, on2, off2;
  logic [3:0] ch1, ch2;
  logic [6:0] nt1, nt2, vel1, vel2;

  int total  = 0;
  int passed = 0;

  always #10 clk = ~clk;

  midi_parser #(.OMNI(1'b1), .CHANNEL(4'd0)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .note_on(on1), .note_off(off1), .channel(ch1), .note(nt1), .velocity(vel1)
  );

  midi_parser #(.OMNI(1'b0), .CHANNEL(4'd2)) dut_ch2 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .note_on(on2), .note_off(off2), .channel(ch2), .note(nt2), .velocity(vel2)
  );

  // Present one byte for one cycle. Return at the following falling edge,
  // when any resulting strobe is visible.
  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
  endtask

  // Compare the packed event vector {on, off, channel, note, velocity}.
  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
  endtask

  function automatic logic [19:0] ev(input logic on, input logic off, input logic [3:0] c,
                                     input logic [6:0] n, input logic [6:0] v);
    return {on, off, c, n, v};
  endfunction

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_state", {on1, off1, ch1, nt1, vel1}, ev(0, 0, 4'h0, 7'h00, 7'h00));
    chk("reset_state_ch2", {on2, off2, ch2, nt2, vel2}, ev(0, 0, 4'h0, 7'h00, 7'h00));

    // Basic note-on.
    send(8'h90);
    send(8'h40);
    chk("basic_no_early", {on1, off1}, 2'b00);
    send(8'h20);
    chk("basic_note_on", {on1, off1, ch1, nt1, vel1}, ev(1, 0, 4'h0, 7'h40, 7'h20));
    chk("ch2_ignores_ch0", {on2, off2, ch2, nt2, vel2}, ev(0, 0, 4'h0, 7'h00, 7'h00));
    idle_cycle();
    chk("strobe_one_cycle", {on1, off1, ch1, nt1, vel1}, ev(0, 0, 4'h0, 7'h40, 7'h20));

    // Running status, with zero velocity giving note-off.
    send(8'h93);
    send(8'h3C);
    send(8'h10);
    chk("rs_note_on", {on1, off1, ch1, nt1, vel1}, ev(1, 0, 4'h3, 7'h3C, 7'h10));
    send(8'h3E);
    chk("rs_hold", {on1, off1, ch1, nt1, vel1}, ev(0, 0, 4'h3, 7'h3C, 7'h10));
    send(8'h00);
    chk("rs_vel0_off", {on1, off1, ch1, nt1, vel1}, ev(0, 1, 4'h3, 7'h3E, 7'h00));

    // Realtime bytes interleaved.
    send(8'h80);
    send(8'hF8);
    send(8'h40);
    send(8'hFE);
    chk("rt_no_early", {on1, off1}, 2'b00);
    send(8'h7F);
    chk("rt_note_off", {on1, off1, ch1, nt1, vel1}, ev(0, 1, 4'h0, 7'h40, 7'h7F));

    // SysEx clears running status.
    send(8'hF0);
    send(8'h41);
    send(8'h10);
    send(8'hF7);
    send(8'h40);
    send(8'h20);
    chk("sysex_no_event", {on1, off1, ch1, nt1, vel1}, ev(0, 0, 4'h0, 7'h40, 7'h7F));
    send(8'h91);
    send(8'h40);
    send(8'h20);
    chk("after_sysex_on", {on1, off1, ch1, nt1, vel1}, ev(1, 0, 4'h1, 7'h40, 7'h20));
    chk("ch2_ignores_ch1", {on2, off2, ch2, nt2, vel2}, ev(0, 0, 4'h0, 7'h00, 7'h00));

    // Reset mid-message, with a byte arriving during reset.
    send(8'h90);
    send(8'h40);
    reset    = 1'b1;
    in_data  = 8'h20;
    in_valid = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("reset_mid_msg", {on1, off1, ch1, nt1, vel1}, ev(0, 0, 4'h0, 7'h00, 7'h00));
    send(8'h20);
    send(8'h41);
    chk("post_reset_data", {on1, off1, ch1, nt1, vel1}, ev(0, 0, 4'h0, 7'h00, 7'h00));

    // Other channel messages are skipped.
    send(8'hB0);
    send(8'h07);
    send(8'h64);
    chk("ctrl_change_skip", {on1, off1, ch1, nt1, vel1}, ev(0, 0, 4'h0, 7'h00, 7'h00));
    send(8'hC5);
    send(8'h01);
    chk("prog_change_skip", {on1, off1, ch1, nt1, vel1}, ev(0, 0, 4'h0, 7'h00, 7'h00));

    // A status byte aborts a partial note message.
    send(8'h90);
    send(8'h40);
    send(8'h95);
    chk("abort_no_event", {on1, off1}, 2'b00);
    send(8'h30);
    send(8'h31);
    chk("abort_new_msg", {on1, off1, ch1, nt1, vel1}, ev(1, 0, 4'h5, 7'h30, 7'h31));

    // Channel filter on the CHANNEL=2 instance.
    send(8'h91);
    send(8'h40);
    send(8'h20);
    chk("filter_drop_ch1", {on2, off2, ch2, nt2, vel2}, ev(0, 0, 4'h0, 7'h00, 7'h00));
    send(8'h92);
    send(8'h40);
    send(8'h20);
    chk("filter_pass_ch2", {on2, off2, ch2, nt2, vel2}, ev(1, 0, 4'h2, 7'h40, 7'h20));
    chk("omni_ch2", {on1, off1, ch1, nt1, vel1}, ev(1, 0, 4'h2, 7'h40, 7'h20));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/midi_parser.md
MIDI_PARSER -- requirements
Module: midi_parser

Interface
REQ-001 Parameter OMNI, default 1: 1 = accept all channels; 0 = accept only channel CHANNEL.
REQ-002 Parameter CHANNEL, default 0: 4-bit channel number used when OMNI=0.
REQ-003 clk  input  1  system clock, 50 MHz domain; the block has one clock.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 in_data  input  8  received byte from the UART receiver.
REQ-006 in_valid  input  1  one-cycle strobe; in_data is valid in that cycle.
REQ-007 note_on  output  1  one-cycle strobe: a note-on event is presented.
REQ-008 note_off  output  1  one-cycle strobe: a note-off event is presented.
REQ-009 channel  output  4  channel of the last event.
REQ-010 note  output  7  note number of the last event.
REQ-011 velocity  output  7  velocity of the last event.

Function
REQ-012 State machine states: IDLE (no running status), DATA1, DATA2, SKIP1, SKIP2, SYSEX.
REQ-013 Bytes are processed only in cycles where in_valid=1; when in_valid=0, state is held and strobes are 0.
REQ-014 Realtime bytes 0xF8-0xFF are ignored in every state: no state, status or output change.
REQ-015 Byte 0xF0 clears running status and enters SYSEX; SYSEX ignores data bytes, and 0xF7 returns to IDLE.
REQ-016 Any other system-common byte (0xF1-0xF7) clears running status and enters IDLE.
REQ-017 Status byte 0x80-0xBF or 0xE0-0xEF is latched as running status, then DATA1 (0x8x/0x9x) or SKIP2 (others, two data bytes).
REQ-018 Status byte 0xC0-0xDF is latched as running status, then SKIP1 (one data byte).
REQ-019 A status byte arriving in any state aborts the partial message and is handled per REQ-015..018; no event is emitted for the aborted message.
REQ-020 DATA1 on a data byte: latch note[6:0], go to DATA2.
REQ-021 DATA2 on a data byte: latch velocity[6:0], emit the event, return to DATA1 (running status kept).
REQ-022 SKIP2 consumes two data bytes and SKIP1 consumes one; both then return to their first skip state under the running status, with no output.
REQ-023 A data byte in IDLE is discarded.
REQ-024 Event type: 0x9n with velocity != 0 gives note_on; 0x8n, or 0x9n with velocity 0, gives note_off.
REQ-025 Latency: the strobe is asserted in the cycle after the in_valid cycle of the final data byte, for exactly one cycle.
REQ-026 channel, note and velocity update in the same cycle as the strobe and hold until the next event.
REQ-027 note_on and note_off are never asserted simultaneously.
REQ-028 With OMNI=0, a message whose channel != CHANNEL is parsed normally (state advances) but emits no strobe and leaves the outputs unchanged.

Reset
REQ-029 On reset, the state is IDLE and running status is cleared.
REQ-030 On reset, note_on=0, note_off=0, channel=0, note=0, velocity=0.
REQ-031 Reset mid-message discards the partial message; after reset, data bytes are ignored until a new status byte arrives.
REQ-032 A byte with in_valid=1 in the same cycle as reset is dropped.

Structure
REQ-033 The MIDI status constants shall live in the shared include midi_defs.vh, included by midi_parser and by the synth voice allocator that consumes its events:
- NOTE_OFF 0x80, NOTE_ON 0x90, SYSEX_START 0xF0, SYSEX_END 0xF7, REALTIME_MIN 0xF8
REQ-034 The block shall be a single flat module with no sub-modules; the UART receiver is instantiated beside it in top, not inside it.

Verification
REQ-035 Bytes 0x90,0x40,0x20 -> one note_on cycle with channel=0, note=0x40, velocity=0x20, one cycle after the third byte.
REQ-036 Running status: 0x93,0x3C,0x10,0x3E,0x00 -> note_on (ch3, 0x3C, 0x10), then note_off (ch3, 0x3E, 0x00).
REQ-037 Realtime interleave: 0x80,0xF8,0x40,0xFE,0x7F -> single note_off (ch0, 0x40, 0x7F).
REQ-038 0xF0,0x41,0x10,0xF7,0x40,0x20 -> no events (running status cleared); then 0x91,0x40,0x20 -> note_on ch1.
REQ-039 0x90,0x40 then reset then 0x20,0x41 -> no event; 0xB0,0x07,0x64 -> no event; 0xC5,0x01 -> no event.
REQ-040 OMNI=0, CHANNEL=2: 0x91,0x40,0x20 -> no event; 0x92,0x40,0x20 -> note_on ch2.
